// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder: single-outstanding load/store responder for the core's
// multi-cycle control unit. It captures one request, waits WAIT cycles with
// hold asserted, then resolves it against a word-organised array with
// little-endian byte-lane merging on stores and lane extraction plus
// sign/zero extension on loads. Faulted requests never touch the array.
module lsu_mem_responder #(
  parameter int DEPTH = 1024,
  parameter int WAIT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rmem,
  input  logic        wmem,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  mem_type,
  input  logic        mem_sign,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        wdone,
  output logic        err,
  output logic        hold
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;

  logic        req_r;
  logic        req_w;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_type;

  logic [31:0] mem [DEPTH];

  logic        cur_r;
  logic        cur_w;
  logic        cur_sign;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [1:0]  cur_type;

  logic             accept;
  logic             go_resp;
  logic             in_range;
  logic             fault;
  logic [IDX_W-1:0] idx;
  logic [3:0]       lane_en;
  logic [31:0]      lane_data;
  logic [31:0]      old_word;
  logic [31:0]      merged;
  logic [31:0]      shifted;
  logic [31:0]      load_val;

  // Resolve against the live inputs in IDLE (only reachable as a response when WAIT=0), else the latched request
  always_comb begin
    if (state == IDLE) begin
      cur_r     = rmem;
      cur_w     = wmem;
      cur_sign  = mem_sign;
      cur_addr  = addr;
      cur_wdata = wdata;
      cur_type  = mem_type;
    end else begin
      cur_r     = req_r;
      cur_w     = req_w;
      cur_sign  = req_sign;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_type  = req_type;
    end
  end

  assign accept   = (state == IDLE) && (rmem || wmem);
  assign go_resp  = (accept && (WAIT == 0)) || ((state == BUSY) && (cnt == 4'd0));
  assign in_range = {2'b00, cur_addr[31:2]} < 32'(DEPTH);
  assign idx      = cur_addr[IDX_W+1:2];
  assign old_word = mem[idx];
  assign fault    = (cur_type == 2'b11)
                  | ((cur_type == 2'b01) & cur_addr[0])
                  | ((cur_type == 2'b10) & (|cur_addr[1:0]))
                  | ~in_range
                  | (cur_r & cur_w);

  // Lane selection shared by stores (merge into old word) and loads (extract and extend)
  always_comb begin
    lane_en   = 4'b0000;
    lane_data = cur_wdata;
    load_val  = old_word;
    shifted   = old_word >> {cur_addr[1:0], 3'b000};
    case (cur_type)
      2'b00: begin
        lane_en   = 4'b0001 << cur_addr[1:0];
        lane_data = {4{cur_wdata[7:0]}};
        load_val  = {{24{~cur_sign & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        lane_en   = cur_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{cur_wdata[15:0]}};
        load_val  = {{16{~cur_sign & shifted[15]}}, shifted[15:0]};
      end
      2'b10: begin
        lane_en   = 4'b1111;
        lane_data = cur_wdata;
        load_val  = old_word;
      end
      default: begin
        lane_en   = 4'b0000;
        lane_data = cur_wdata;
        load_val  = 32'd0;
      end
    endcase
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
    end
  end

  // Commit a good store on the edge that enters RESP; a reset on that edge drops it
  always_ff @(posedge clk) begin
    if (!rst && go_resp && cur_w && !fault) begin
      mem[idx] <= merged;
    end
  end

  // Control FSM with registered hold, response pulses and load data
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      hold      <= 1'b0;
      rvalid    <= 1'b0;
      wdone     <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'd0;
      req_r     <= 1'b0;
      req_w     <= 1'b0;
      req_sign  <= 1'b0;
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
      req_type  <= 2'b00;
    end else begin
      rvalid <= 1'b0;
      wdone  <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_r     <= rmem;
            req_w     <= wmem;
            req_sign  <= mem_sign;
            req_addr  <= addr;
            req_wdata <= wdata;
            req_type  <= mem_type;
            if (WAIT == 0) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= WAIT_LOAD;
              hold  <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state <= RESP;
            hold  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          hold  <= 1'b0;
        end
      endcase
      if (go_resp) begin
        if (fault) begin
          err   <= 1'b1;
          rdata <= 32'd0;
        end else if (cur_w) begin
          wdone <= 1'b1;
        end else begin
          rvalid <= 1'b1;
          rdata  <= load_val;
        end
      end
    end
  end

endmodule

// File: doc/lsu_mem_responder.md
# lsu_mem_responder

Data-memory responder that services the load/store requests issued by the core's multi-cycle control unit. It captures one request per transaction (`rmem`/`wmem`, address, store data, `mem_type`, `mem_sign`) and runs it against a word-organised synchronous memory array. It performs byte-lane merging on stores and lane extraction with sign/zero extension on loads. While a transaction is pending it drives `hold` back to the core, and it reports completion with `rvalid`/`wdone` pulses and faults with `err`.

## Interface
- `DEPTH`, 1024: number of 32-bit words in the array. Word index is `addr[31:2]`.
- `WAIT`, 1: extra wait states per access, range 0..15.
- `clk`  in  1: single clock. All logic is rising-edge.
- `rst`  in  1: reset, synchronous and active-high.
- `rmem`  in  1: read request, sampled in IDLE only.
- `wmem`  in  1: write request, sampled in IDLE only.
- `addr`  in  32: byte address.
- `wdata`  in  32: store data, right-aligned.
- `mem_type`  in  2: access size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `mem_sign`  in  1: load extension. 0 = sign-extend, 1 = zero-extend (unsigned). Ignored on stores.
- `rdata`  out  32: extended load data. Registered; holds its last value between responses.
- `rvalid`  out  1: one-cycle pulse when a load completes successfully.
- `wdone`  out  1: one-cycle pulse when a store has been committed.
- `err`  out  1: one-cycle pulse when a request is faulted.
- `hold`  out  1: stall to the core. High while the transaction is in BUSY.

## Operation
- FSM has three states: IDLE, BUSY, RESP.
- **IDLE**
  - On `rmem|wmem`, latch `addr`, `wdata`, `mem_type`, `mem_sign` and the request kind.
  - Go to BUSY if `WAIT`>0, otherwise go to RESP.
- **BUSY**
  - Wait counter loads `WAIT-1` and decrements each cycle.
  - At 0, go to RESP.
- **RESP**
  - Drive exactly one of `rvalid`, `wdone`, `err` for one cycle, then return to IDLE.
  - A store writes the array in this cycle.
  - A load registers `rdata` in this cycle.
- Fault conditions, all checked on the latched request:
  - `mem_type`=11.
  - Misalignment: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Word index ≥ `DEPTH`.
  - `rmem` and `wmem` both high.
- Effect of a fault: no array write, `rdata` forced to 0, only `err` pulses.
- Store lane merge, little-endian:
  - Byte: `wdata[7:0]` goes to lane `addr[1:0]`.
  - Half: `wdata[15:0]` goes to lanes `{addr[1],0}` and `{addr[1],1}`.
  - Word: all four lanes.
  - Unselected lanes keep their contents.
- Load extraction:
  - Select the same lanes as for a store.
  - Extend to 32 bits: replicate the top selected bit when `mem_sign`=0, zero-fill when `mem_sign`=1.
  - Word loads ignore `mem_sign`.
- Requests arriving in BUSY or RESP are ignored, not queued. The core must not issue while `hold` is high.

## Timing
- Request is sampled at edge T in IDLE. The response pulse is high during cycle T+1+`WAIT`.
- `hold` is high for cycles T+1 .. T+`WAIT` and low in RESP. With `WAIT`=0 it never rises.
- A new request is accepted at the earliest in the cycle after RESP, so back-to-back spacing is `WAIT`+2 cycles.
- A store is visible to a load issued after its `wdone`.
- Reset behaviour:
  - FSM returns to IDLE.
  - Counter goes to 0.
  - `rdata`, `rvalid`, `wdone`, `err`, `hold` all go to 0.
  - An in-flight store is dropped, never partially written.
  - Array contents are not initialised by reset.
- `rst` asserted in the same cycle as a request: reset wins and the request is discarded.
- Counter at `WAIT`=15 does not wrap. It saturates into the RESP transition.

## Test plan
- **Word store then load.** `WAIT`=1. Store word 0xDEADBEEF to 0x10. Then load word from 0x10.
  - `wdone` at T+2, `hold` high at T+1 only.
  - Load returns `rdata`=0xDEADBEEF with `rvalid` at T+2.
- **Byte load extension.** Load byte from 0x13 with `mem_sign`=0 → 0xFFFFFFDE. Load byte from 0x11 with `mem_sign`=1 → 0x000000BE.
- **Half store merge.** Store half 0x1234 to 0x12 over 0xDEADBEEF. Then load word from 0x10 → 0x1234BEEF. Load half from 0x12 with `mem_sign`=0 → 0x00001234.
- **Faults.** For each of the following, expect `err` pulse only, `rvalid`=`wdone`=0, `rdata`=0, and memory at 0x10 unchanged:
  - half load at 0x11;
  - word store at 0x12;
  - `mem_type`=11;
  - address `DEPTH`*4;
  - `rmem`=`wmem`=1.
- **Ignored request while busy.** `WAIT`=3. Issue a word load, and assert a second `rmem` during BUSY.
  - Exactly one `rvalid`, at T+4.
  - `hold` high for T+1..T+3.
  - Second request ignored.
- **Reset mid-operation.** Assert `rst` during BUSY of a store of 0xCAFEF00D to 0x20.
  - All outputs are 0 on the next cycle and no `wdone` occurs.
  - A subsequent load of 0x20 does not return 0xCAFEF00D, given the location was pre-loaded with 0x0.
